// File: rtl/jg_div_seq.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, signed or
// unsigned operands, divide-by-zero detection and a ready/valid request port.
module jg_div_seq #(
  parameter int unsigned W = 8
) (
  input  logic         CCLK,
  input  logic         SSE_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] Dividend,
  input  logic [W-1:0] Divisor,
  input  logic         Signed,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         DivByZero,
  output logic         DivResult
);

  localparam int unsigned CW = $clog2(W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;

  logic          ready_d;
  logic [W-1:0]  quotient_d, remainder_d;
  logic          dbz_d, result_d;

  logic          dvd_neg, dvs_neg;
  logic [W-1:0]  dvd_mag, dvs_mag;
  logic [W:0]    shifted;
  logic          fits;
  logic [W-1:0]  step_rem, step_quo;

  // Operand magnitudes and sign flags, taken straight from the request port.
  always_comb begin
    dvd_neg = Signed & Dividend[W-1];
    dvs_neg = Signed & Divisor[W-1];
    dvd_mag = dvd_neg ? (~Dividend + W'(1)) : Dividend;
    dvs_mag = dvs_neg ? (~Divisor + W'(1)) : Divisor;
  end

  // One restoring step: shift the next dividend bit in and trial-subtract.
  // The partial remainder always stays below the divisor, so W bits hold it;
  // only the shifted value needs the extra bit.
  always_comb begin
    shifted  = {rem_q, quo_q[W-1]};
    fits     = shifted >= {1'b0, dvs_q};
    step_rem = fits ? W'(shifted - {1'b0, dvs_q}) : shifted[W-1:0];
    step_quo = {quo_q[W-2:0], fits};
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    ready_d     = i_ready;
    quotient_d  = quotient;
    remainder_d = remainder;
    dbz_d       = DivByZero;
    result_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (i_valid) begin
          ready_d = 1'b0;
          if (Divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = Dividend;
            dbz_d       = 1'b1;
            result_d    = 1'b1;
          end else begin
            state_d   = S_RUN;
            cnt_d     = CW'(W);
            rem_d     = '0;
            quo_d     = dvd_mag;
            dvs_d     = dvs_mag;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
          end
        end
      end
      S_RUN: begin
        ready_d = 1'b0;
        rem_d   = step_rem;
        quo_d   = step_quo;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          quotient_d  = neg_quo_q ? (~step_quo + W'(1)) : step_quo;
          remainder_d = neg_rem_q ? (~step_rem + W'(1)) : step_rem;
          dbz_d       = 1'b0;
          result_d    = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CCLK or negedge SSE_n) begin
    if (!SSE_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge CCLK or negedge SSE_n) begin
    if (!SSE_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      i_ready   <= 1'b1;
      quotient  <= '0;
      remainder <= '0;
      DivByZero <= 1'b0;
      DivResult <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      i_ready   <= ready_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
      DivByZero <= dbz_d;
      DivResult <= result_d;
    end
  end

endmodule

// File: tb/tb_jg_div_seq.sv
// Directed bench for jg_div_seq: an 8-bit instance for most scenarios and a
// 16-bit instance for the abort-and-restart case.
module tb_jg_div_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8_n, v8, rdy8, s8, dbz8, res8;
  logic [7:0]  a8, b8, q8, r8;
  logic        rst16_n, v16, rdy16, s16, dbz16, res16;
  logic [15:0] a16, b16, q16, r16;

  int n_checks = 0;
  int n_pass   = 0;

  jg_div_seq #(.W(8)) u_div8 (
    .CCLK(clk), .SSE_n(rst8_n), .i_valid(v8), .i_ready(rdy8),
    .Dividend(a8), .Divisor(b8), .Signed(s8),
    .quotient(q8), .remainder(r8), .DivByZero(dbz8), .DivResult(res8)
  );

  jg_div_seq #(.W(16)) u_div16 (
    .CCLK(clk), .SSE_n(rst16_n), .i_valid(v16), .i_ready(rdy16),
    .Dividend(a16), .Divisor(b16), .Signed(s16),
    .quotient(q16), .remainder(r16), .DivByZero(dbz16), .DivResult(res16)
  );

  // Issue one 8-bit request and wait (bounded) for its result pulse.
  // lat = edges after the accept edge until DivResult is seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output logic [7:0] q, output logic [7:0] r, output logic dbz,
                      output int lat, output bit busy_ok, output bit one_pulse);
    @(negedge clk);
    a8 = a; b8 = b; s8 = s; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'hA5; b8 = 8'h00; s8 = ~s;
    busy_ok = (rdy8 === 1'b0);
    lat = 0;
    while (res8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (rdy8 !== 1'b0) busy_ok = 1'b0;
    end
    q = q8; r = r8; dbz = dbz8;
    @(posedge clk); #1;
    one_pulse = (res8 === 1'b0) && (rdy8 === 1'b1);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output int lat);
    @(negedge clk);
    a16 = a; b16 = b; s16 = 1'b0; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    lat = 0;
    while (res16 !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    q = q16; r = r16;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst8_n = 1'b1; rst16_n = 1'b1;
    #2; rst8_n = 1'b0; rst16_n = 1'b0;
    #1;
    n_checks++;
    if ({rdy8, res8, q8, r8, dbz8} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0})
      $display("FAIL reset8 got rdy=%b res=%b q=%h r=%h dbz=%b want 1 0 00 00 0", rdy8, res8, q8, r8, dbz8);
    else n_pass++;
    n_checks++;
    if ({rdy16, res16, q16, r16, dbz16} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0})
      $display("FAIL reset16 got rdy=%b res=%b q=%h r=%h dbz=%b want 1 0 0000 0000 0", rdy16, res16, q16, r16, dbz16);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst8_n = 1'b1; rst16_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    logic [7:0] q, r; logic dbz; int lat; bit busy, one;
    run8(8'd200, 8'd7, 1'b0, q, r, dbz, lat, busy, one);
    n_checks++;
    if (lat != 8) $display("FAIL u_latency got %0d want 8", lat); else n_pass++;
    n_checks++;
    if ({q, r, dbz} !== {8'h1C, 8'h04, 1'b0})
      $display("FAIL u_200_7 got q=%h r=%h dbz=%b want 1c 04 0", q, r, dbz);
    else n_pass++;
    n_checks++;
    if (!busy) $display("FAIL u_busy got i_ready=1 while running want 0"); else n_pass++;
    n_checks++;
    if (!one) $display("FAIL u_pulse got pulse not single or not idle after want single"); else n_pass++;
    run8(8'd5, 8'd9, 1'b0, q, r, dbz, lat, busy, one);
    n_checks++;
    if ({q, r} !== {8'h00, 8'h05}) $display("FAIL u_5_9 got q=%h r=%h want 00 05", q, r); else n_pass++;
    run8(8'hFF, 8'h10, 1'b0, q, r, dbz, lat, busy, one);
    n_checks++;
    if ({q, r} !== {8'h0F, 8'h0F}) $display("FAIL u_ff_10 got q=%h r=%h want 0f 0f", q, r); else n_pass++;
    run8(8'h80, 8'hFF, 1'b0, q, r, dbz, lat, busy, one);
    n_checks++;
    if ({q, r} !== {8'h00, 8'h80}) $display("FAIL u_80_ff got q=%h r=%h want 00 80", q, r); else n_pass++;
  endtask

  task automatic test_signed;
    logic [7:0] q, r; logic dbz; int lat; bit busy, one;
    run8(8'hF9, 8'h02, 1'b1, q, r, dbz, lat, busy, one);
    n_checks++;
    if ({q, r} !== {8'hFD, 8'hFF}) $display("FAIL s_m7_2 got q=%h r=%h want fd ff", q, r); else n_pass++;
    run8(8'h80, 8'hFF, 1'b1, q, r, dbz, lat, busy, one);
    n_checks++;
    if ({q, r, dbz} !== {8'h80, 8'h00, 1'b0})
      $display("FAIL s_overflow got q=%h r=%h dbz=%b want 80 00 0", q, r, dbz);
    else n_pass++;
    run8(8'h07, 8'hFE, 1'b1, q, r, dbz, lat, busy, one);
    n_checks++;
    if ({q, r} !== {8'hFD, 8'h01}) $display("FAIL s_7_m2 got q=%h r=%h want fd 01", q, r); else n_pass++;
    run8(8'hF9, 8'hFE, 1'b1, q, r, dbz, lat, busy, one);
    n_checks++;
    if ({q, r} !== {8'h03, 8'hFF}) $display("FAIL s_m7_m2 got q=%h r=%h want 03 ff", q, r); else n_pass++;
  endtask

  task automatic test_div_by_zero;
    logic [7:0] q, r; logic dbz; int lat; bit busy, one;
    run8(8'h55, 8'h00, 1'b0, q, r, dbz, lat, busy, one);
    n_checks++;
    if (lat != 0) $display("FAIL dbz_latency got %0d want 0", lat); else n_pass++;
    n_checks++;
    if ({q, r, dbz} !== {8'hFF, 8'h55, 1'b1})
      $display("FAIL dbz_result got q=%h r=%h dbz=%b want ff 55 1", q, r, dbz);
    else n_pass++;
    n_checks++;
    if (!one) $display("FAIL dbz_pulse got pulse not single want single"); else n_pass++;
    run8(8'd9, 8'd3, 1'b0, q, r, dbz, lat, busy, one);
    n_checks++;
    if ({q, r, dbz} !== {8'h03, 8'h00, 1'b0})
      $display("FAIL dbz_clear got q=%h r=%h dbz=%b want 03 00 0", q, r, dbz);
    else n_pass++;
    run8(8'h80, 8'h00, 1'b1, q, r, dbz, lat, busy, one);
    n_checks++;
    if ({q, r, dbz} !== {8'hFF, 8'h80, 1'b1})
      $display("FAIL dbz_signed got q=%h r=%h dbz=%b want ff 80 1", q, r, dbz);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    int pulses;
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd5; s8 = 1'b0; v8 = 1'b1;
    @(posedge clk); #1; v8 = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst8_n = 1'b0;
    #1;
    n_checks++;
    if ({rdy8, res8, q8, r8, dbz8} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0})
      $display("FAIL async_reset got rdy=%b res=%b q=%h r=%h dbz=%b want 1 0 00 00 0", rdy8, res8, q8, r8, dbz8);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst8_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (res8 === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || rdy8 !== 1'b1)
      $display("FAIL async_no_pulse got pulses=%0d rdy=%b want 0 1", pulses, rdy8);
    else n_pass++;
  endtask

  task automatic test_handshake;
    logic [7:0] exp_q[$];
    logic [7:0] exp_r[$];
    int acc_k[$];
    logic [7:0] a, b;
    @(negedge clk);
    for (int k = 0; k < 42; k++) begin
      a = 8'((50 + 17 * k) % 256);
      b = 8'(k % 7 + 1);
      a8 = a; b8 = b; s8 = 1'b0; v8 = (k < 30);
      if (k < 30 && rdy8 === 1'b1) begin
        exp_q.push_back(a / b);
        exp_r.push_back(a % b);
        acc_k.push_back(k);
      end
      @(posedge clk); #1;
      if (res8 === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL hs_extra got unexpected DivResult at step %0d want none", k);
        else begin
          if ({q8, r8} !== {exp_q[0], exp_r[0]})
            $display("FAIL hs_result got q=%h r=%h want %h %h", q8, r8, exp_q[0], exp_r[0]);
          else n_pass++;
          void'(exp_q.pop_front());
          void'(exp_r.pop_front());
        end
      end
      @(negedge clk);
    end
    v8 = 1'b0;
    n_checks++;
    if (acc_k.size() != 3 || exp_q.size() != 0)
      $display("FAIL hs_accepts got accepts=%0d outstanding=%0d want 3 0", acc_k.size(), exp_q.size());
    else n_pass++;
    if (acc_k.size() == 3) begin
      n_checks++;
      if (acc_k[1] - acc_k[0] != 10 || acc_k[2] - acc_k[1] != 10)
        $display("FAIL hs_spacing got %0d %0d want 10 10", acc_k[1] - acc_k[0], acc_k[2] - acc_k[1]);
      else n_pass++;
    end
  endtask

  task automatic test_abort16;
    logic [15:0] q, r; int lat, pulses;
    run16(16'd1000, 16'd7, q, r, lat);
    n_checks++;
    if ({q, r} !== {16'h008E, 16'h0006}) $display("FAIL w16_1000_7 got q=%h r=%h want 008e 0006", q, r); else n_pass++;
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h0005; s16 = 1'b0; v16 = 1'b1;
    @(posedge clk); #1; v16 = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst16_n = 1'b0;
    #1;
    n_checks++;
    if ({rdy16, res16, q16, r16, dbz16} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0})
      $display("FAIL abort_outputs got rdy=%b res=%b q=%h r=%h dbz=%b want 1 0 0000 0000 0", rdy16, res16, q16, r16, dbz16);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst16_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (res16 === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL abort_no_pulse got %0d pulses want 0", pulses); else n_pass++;
    run16(16'hFFFF, 16'h0003, q, r, lat);
    n_checks++;
    if ({q, r} !== {16'h5555, 16'h0000}) $display("FAIL abort_restart got q=%h r=%h want 5555 0000", q, r); else n_pass++;
    n_checks++;
    if (lat != 16) $display("FAIL w16_latency got %0d want 16", lat); else n_pass++;
  endtask

  initial begin
    v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_async_reset();
    test_handshake();
    test_abort16();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jg_div_seq.md
Name: jg_div_seq

Overview:
- Parametrised iterative radix-2 integer divider; successor to the single-cycle add-based divide stub in the test harness.
- Computes quotient and remainder of a W-bit dividend by a W-bit divisor, one quotient bit per clock.
- Supports signed and unsigned modes, divide-by-zero detection and a ready/valid input handshake.
- Sits behind the harness register interface as the DUT; results pulse on DivResult exactly as the earlier stub did.

Parameters:
- W, 8, operand, quotient and remainder width in bits, W >= 2.
- CW, $clog2(W)+1, iteration counter width; derived, do not override.

Ports:
- CCLK  input  1  clock, rising-edge active.
- SSE_n  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  request strobe; sampled only when i_ready=1.
- i_ready  output  1  divider idle and able to accept a request.
- Dividend  input  W  dividend; signed two's complement when Signed=1.
- Divisor  input  W  divisor; signed two's complement when Signed=1.
- Signed  input  1  mode select, sampled with the request.
- quotient  output  W  quotient result.
- remainder  output  W  remainder result.
- DivByZero  output  1  last result was a divide by zero.
- DivResult  output  1  one-cycle pulse: quotient, remainder and DivByZero are newly valid.

Behaviour:
- Reset (SSE_n=0, asynchronous): state=IDLE, i_ready=1, quotient=0, remainder=0, DivByZero=0, DivResult=0, counter=0. Reset mid-operation abandons the division; no DivResult pulse follows.
- Accept: a request is accepted on the rising edge where i_valid=1 and i_ready=1 (edge E). Dividend, Divisor and Signed are latched at E. i_valid while i_ready=0 is ignored; requests are not queued.
- States:
  - IDLE: i_ready=1. On accept with Divisor!=0, go to RUN and load counter=W. On accept with Divisor=0, go to DONE.
  - RUN: i_ready=0. Perform one shift-subtract step per edge and decrement the counter. The edge that brings the counter to 0 goes to DONE.
  - DONE: i_ready=0, DivResult=1 for exactly one cycle. Always returns to IDLE on the next edge.
- Latency:
  - Normal: DivResult is high in the cycle following edge E+W.
  - Divide-by-zero: DivResult is high in the cycle following edge E.
  - Minimum spacing between accepts: W+2 cycles normal, 2 cycles divide-by-zero.
- Unsigned arithmetic: restoring division on a W+1-bit partial remainder. Quotient = floor(Dividend/Divisor); remainder = Dividend mod Divisor, always less than Divisor.
- Signed arithmetic:
  - Operate on magnitudes and fix the signs in the final step.
  - Quotient truncates toward zero and is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Invariant: quotient*Divisor + remainder = Dividend, modulo 2^W.
  - Overflow case, most-negative / -1: quotient = most-negative (wraps), remainder=0, DivByZero=0.
- Divide-by-zero (both modes): quotient = all ones, remainder = Dividend, DivByZero=1.
- DivByZero updates only in the DONE cycle: 1 for a zero divisor, otherwise 0.
- quotient, remainder and DivByZero update only in the DONE cycle and hold until the next DONE or reset.
- Input changes after E have no effect on the division in progress.

Test Plan:
- Reset, W=8: pulse SSE_n low asynchronously mid-cycle -> i_ready=1, DivResult=0, quotient=0x00, remainder=0x00, DivByZero=0 immediately.
- Unsigned, W=8: Dividend=200, Divisor=7, Signed=0 -> DivResult high exactly after edge E+8, quotient=0x1C, remainder=0x04, DivByZero=0, i_ready=0 from E through the DONE cycle.
- Signed, W=8, Signed=1:
  - Dividend=0xF9 (-7), Divisor=0x02 -> quotient=0xFD (-3), remainder=0xFF (-1).
  - Dividend=0x80, Divisor=0xFF -> quotient=0x80, remainder=0x00.
- Divide-by-zero, W=8: Dividend=0x55, Divisor=0 -> DivResult in the cycle after E, quotient=0xFF, remainder=0x55, DivByZero=1. The next valid divide clears DivByZero to 0.
- Handshake: hold i_valid=1 with changing operands for 30 cycles -> accepts only when i_ready=1, one accept every 10 cycles, each result matches the operands sampled at its own accept edge.
- Abort, W=16: assert SSE_n low 5 cycles after accept -> no DivResult pulse; outputs read 0. A fresh request, 0xFFFF/0x0003 unsigned, then yields quotient=0x5555, remainder=0x0000.
